// File: rtl/grf_wb_arbiter_pkg.sv
// grf_wb_arbiter_pkg
//   Shared constants and types for the GRF writeback arbiter slice.
//   GRF_AW / GRF_DW : register-file address and data widths.
//   wb_ent_t        : one writeback record {a3, wd, pc}, used both for the
//                     buffered S results and for the granted write.
//   a3_live()       : true when a destination register actually gets written
//                     ($0 writes are discarded).
package grf_wb_arbiter_pkg;

   localparam int GRF_AW = 5;
   localparam int GRF_DW = 32;

   typedef struct packed {
      logic [GRF_AW-1:0] a3;
      logic [GRF_DW-1:0] wd;
      logic [GRF_DW-1:0] pc;
   } wb_ent_t;

   function automatic logic a3_live(input logic [GRF_AW-1:0] a3);
      return a3 != '0;
   endfunction

endpackage

// File: rtl/grf_wb_arbiter_fifo.sv
// grf_wb_fifo
//   DEPTH-entry circular buffer of writeback records for the secondary (S)
//   source, with two address-match ports for D-stage hazard lookups.
// Ports
//   clk, reset      : clock, asynchronous active-low reset
//   push, wr_ent    : enqueue wr_ent (ignored when full)
//   pop,  rd_ent    : dequeue; rd_ent is the current head
//   full, empty     : occupancy flags
//   count           : number of valid entries, 0..DEPTH
//   m_a1/m_a2       : lookup addresses; hit1/hit2 set when any valid entry
//                     targets that register
module grf_wb_fifo
   import grf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  wb_ent_t                    wr_ent,
   input  logic                       pop,
   output wb_ent_t                    rd_ent,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   input  logic [GRF_AW-1:0]          m_a1,
   input  logic [GRF_AW-1:0]          m_a2,
   output logic                       hit1,
   output logic                       hit2
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_ent_t          mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push, do_pop;
   logic [DEPTH-1:0] vld, m1, m2;

   assign full    = cnt == CW'(DEPTH);
   assign empty   = cnt == '0;
   assign count   = cnt;
   assign rd_ent  = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage carries no reset; validity comes from the pointers and count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_ent;
   end

   // Slot i is valid when its distance from the read pointer (mod DEPTH,
   // DEPTH is a power of two) is below the occupancy.
   for (genvar i = 0; i < DEPTH; i++) begin : g_match
      logic [PW-1:0] off;
      assign off   = PW'(i) - rd_ptr;
      assign vld[i] = CW'(off) < cnt;
      assign m1[i]  = vld[i] && (mem[i].a3 == m_a1);
      assign m2[i]  = vld[i] && (mem[i].a3 == m_a2);
   end

   assign hit1 = |m1;
   assign hit2 = |m2;

endmodule

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter
//   Shares the single GRF write port between the in-order W stage (P,
//   primary) and a multi-cycle unit (S, secondary). S results are buffered in
//   grf_wb_fifo; P wins by default, but an S head that has waited MAX_WAIT
//   cycles forces an S grant and stalls P for that cycle.
// Ports
//   clk, reset                : clock, asynchronous active-low reset
//   p_valid/p_a3/p_wd/p_pc    : W stage write request; p_stall = not taken
//   s_valid/s_a3/s_wd/s_pc    : S result; s_ready = accepted this cycle
//   q_a1/q_a2, pend_hit1/2    : D-stage lookups against pending S writes
//   grf_we/a3/wd/pc           : GRF write port
//   s_count                   : buffered S entries
// Configuration
//   GRF_ARB_TRACE_EN : when defined, prints each GRF write and each S result
//                      dropped for $0. Port list is identical either way.
module grf_wb_arbiter
   import grf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int MAX_WAIT = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   p_valid,
   input  logic [GRF_AW-1:0]      p_a3,
   input  logic [GRF_DW-1:0]      p_wd,
   input  logic [GRF_DW-1:0]      p_pc,
   output logic                   p_stall,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [GRF_AW-1:0]      s_a3,
   input  logic [GRF_DW-1:0]      s_wd,
   input  logic [GRF_DW-1:0]      s_pc,
   input  logic [GRF_AW-1:0]      q_a1,
   input  logic [GRF_AW-1:0]      q_a2,
   output logic                   pend_hit1,
   output logic                   pend_hit2,
   output logic                   grf_we,
   output logic [GRF_AW-1:0]      grf_a3,
   output logic [GRF_DW-1:0]      grf_wd,
   output logic [GRF_DW-1:0]      grf_pc,
   output logic [$clog2(DEPTH):0] s_count
);

   localparam int WW = $clog2(MAX_WAIT + 1);

   wb_ent_t       head, sel;
   logic          full, empty, fhit1, fhit2;
   logic          accept, push, grant_s, grant_p;
   logic [WW-1:0] wait_cnt;

   // s_ready looks only at registered occupancy (plus reset), so a pop in
   // this cycle cannot open the port combinationally.
   assign s_ready = reset && !full;
   assign accept  = s_valid && s_ready;
   assign push    = accept && a3_live(s_a3);

   assign grant_s = reset && !empty && (!p_valid || wait_cnt == WW'(MAX_WAIT));
   assign grant_p = reset && p_valid && !grant_s;
   assign p_stall = grant_s && p_valid;

   grf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (push),
      .wr_ent ('{a3: s_a3, wd: s_wd, pc: s_pc}),
      .pop    (grant_s),
      .rd_ent (head),
      .full   (full),
      .empty  (empty),
      .count  (s_count),
      .m_a1   (q_a1),
      .m_a2   (q_a2),
      .hit1   (fhit1),
      .hit2   (fhit2)
   );

   always_comb begin
      sel = '0;
      if (grant_s)      sel = head;
      else if (grant_p) sel = '{a3: p_a3, wd: p_wd, pc: p_pc};
   end

   assign grf_we = (grant_s || grant_p) && a3_live(sel.a3);
   assign grf_a3 = sel.a3;
   assign grf_wd = sel.wd;
   assign grf_pc = sel.pc;

   // The head being popped this cycle is still in the FIFO and still hits.
   assign pend_hit1 = reset && a3_live(q_a1) && (fhit1 || (push && s_a3 == q_a1));
   assign pend_hit2 = reset && a3_live(q_a2) && (fhit2 || (push && s_a3 == q_a2));

   // Age of the current head while it loses to P; restarts for each new head.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                    wait_cnt <= '0;
      else if (grant_s || empty)     wait_cnt <= '0;
      else if (wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + WW'(1);
   end

`ifdef GRF_ARB_TRACE_EN
   always @(posedge clk) begin
      if (grf_we)
         $display("%d@%h: $%d <= %h", $time, grf_pc, grf_a3, grf_wd);
      if (accept && !a3_live(s_a3))
         $display("%d@%h: drop", $time, s_pc);
   end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
module tb_grf_wb_arbiter;
   import grf_wb_arbiter_pkg::*;

   localparam int DEPTH    = 4;
   localparam int MAX_WAIT = 3;
   localparam int CW       = $clog2(DEPTH) + 1;

   logic          clk = 0, reset = 0;
   logic          p_valid = 0, s_valid = 0;
   logic [4:0]    p_a3 = 0, s_a3 = 0, q_a1 = 0, q_a2 = 0;
   logic [31:0]   p_wd = 0, p_pc = 0, s_wd = 0, s_pc = 0;
   logic          p_stall, s_ready, pend_hit1, pend_hit2, grf_we;
   logic [4:0]    grf_a3;
   logic [31:0]   grf_wd, grf_pc;
   logic [CW-1:0] s_count;

   always #5 clk = ~clk;

   grf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .p_valid(p_valid), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc), .p_stall(p_stall),
      .s_valid(s_valid), .s_ready(s_ready), .s_a3(s_a3), .s_wd(s_wd), .s_pc(s_pc),
      .q_a1(q_a1), .q_a2(q_a2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
      .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
      .s_count(s_count)
   );

   typedef struct {
      logic          we;
      logic [4:0]    a3;
      logic [31:0]   wd, pc;
      logic          stall, rdy, h1, h2;
      logic [CW-1:0] cnt;
   } exp_t;

   typedef struct {
      logic [4:0]  a3;
      logic [31:0] wd, pc;
   } ment_t;

   exp_t  exp_q[$];
   ment_t mq[$];          // reference S buffer, oldest first
   int    cyc = 0;        // cycle index of the expectation being built
   int    head_since = 0; // cycle the current head became the head
   int    checks = 0, errors = 0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] ex);
      checks++;
      if (act !== ex) begin
         errors++;
         $display("FAIL %s @%0t: got %h want %h", n, $time, act, ex);
      end
   endtask

   // One clock cycle of stimulus. Expected outputs come from the queue model:
   // S wins when P is idle or the head has been head for >= MAX_WAIT cycles.
   task automatic step(input bit rst_n, input bit pv, input logic [4:0] pa3,
                       input logic [31:0] pwd, input bit sv, input logic [4:0] sa3,
                       input logic [31:0] swd, input logic [4:0] qa1, input logic [4:0] qa2,
                       output bit acc, output bit stall);
      exp_t  e;
      bit    gs, gp, push, was_empty;
      logic [31:0] ppc, spc;
      ppc = 32'h0040_0000 + 32'(cyc * 4);
      spc = 32'h0080_0000 + 32'(cyc * 4);
      @(posedge clk); #1;
      reset = rst_n; p_valid = pv; p_a3 = pa3; p_wd = pwd; p_pc = ppc;
      s_valid = sv; s_a3 = sa3; s_wd = swd; s_pc = spc; q_a1 = qa1; q_a2 = qa2;
      e = '{we: 0, a3: 0, wd: 0, pc: 0, stall: 0, rdy: 0, h1: 0, h2: 0, cnt: 0};
      acc = 0; stall = 0;
      if (!rst_n) begin
         mq.delete();
      end else begin
         e.cnt = CW'(mq.size());
         e.rdy = mq.size() < DEPTH;
         gs = mq.size() > 0 && (!pv || (cyc - head_since) >= MAX_WAIT);
         gp = pv && !gs;
         if (gs) begin
            e.a3 = mq[0].a3; e.wd = mq[0].wd; e.pc = mq[0].pc; e.we = 1;
         end else if (gp) begin
            e.a3 = pa3; e.wd = pwd; e.pc = ppc; e.we = pa3 != 0;
         end
         e.stall = gs && pv;
         acc  = sv && e.rdy;
         push = acc && sa3 != 0;
         foreach (mq[i]) begin
            if (qa1 != 0 && mq[i].a3 == qa1) e.h1 = 1;
            if (qa2 != 0 && mq[i].a3 == qa2) e.h2 = 1;
         end
         if (push && qa1 != 0 && sa3 == qa1) e.h1 = 1;
         if (push && qa2 != 0 && sa3 == qa2) e.h2 = 1;
         was_empty = mq.size() == 0;
         if (gs) void'(mq.pop_front());
         if (push) mq.push_back('{a3: sa3, wd: swd, pc: spc});
         if (mq.size() > 0 && (gs || was_empty)) head_since = cyc + 1;
         stall = e.stall;
      end
      exp_q.push_back(e);
      cyc++;
   endtask

   // Monitor: compares whatever the DUT presents mid-cycle against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("grf_we",    grf_we,    e.we);
         chk("grf_a3",    grf_a3,    e.a3);
         chk("grf_wd",    grf_wd,    e.wd);
         chk("grf_pc",    grf_pc,    e.pc);
         chk("p_stall",   p_stall,   e.stall);
         chk("s_ready",   s_ready,   e.rdy);
         chk("pend_hit1", pend_hit1, e.h1);
         chk("pend_hit2", pend_hit2, e.h2);
         chk("s_count",   s_count,   e.cnt);
      end
   end

   initial begin
      bit a, st, hold, pv;
      logic [4:0]  pa3;
      logic [31:0] pwd;
      int k;

      // reset state
      repeat (2) step(0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 5'd4, 5'd3, a, st);

      // P only, then P to $0
      repeat (5) step(1, 1, 5'd8, 32'h1234, 0, 0, 0, 5'd8, 0, a, st);
      step(1, 1, 5'd0, 32'h5555, 0, 0, 0, 0, 0, a, st);

      // starvation guard: head forced on the 4th cycle after accept
      step(1, 1, 5'd10, 32'h1, 1, 5'd9, 32'hBEEF, 0, 0, a, st);
      repeat (7) step(1, 1, 5'd10, 32'h2, 0, 0, 0, 5'd9, 0, a, st);

      // full / backpressure: five S results a3=1..5 against continuous P
      k = 1;
      for (int c = 0; c < 40; c++) begin
         step(1, 1, 5'd12, 32'(c), k <= 5, 5'(k), 32'hA000 + 32'(k), 5'(k), 5'd1, a, st);
         if (a && k <= 5) k++;
      end

      // hazard lookup, then a dropped $0 accept
      step(1, 1, 5'd13, 32'h3, 1, 5'd7, 32'h77, 5'd7, 5'd0, a, st);
      repeat (6) step(1, 1, 5'd13, 32'h3, 0, 0, 0, 5'd7, 5'd0, a, st);
      step(1, 0, 0, 0, 1, 5'd0, 32'h99, 5'd0, 5'd0, a, st);

      // idle drain of two entries
      step(1, 1, 5'd14, 32'h4, 1, 5'd20, 32'hC1, 0, 0, a, st);
      step(1, 1, 5'd14, 32'h4, 1, 5'd21, 32'hC2, 0, 0, a, st);
      repeat (4) step(1, 0, 0, 0, 0, 0, 0, 5'd20, 5'd21, a, st);

      // reset mid-traffic with three buffered entries
      for (int c = 0; c < 3; c++)
         step(1, 1, 5'd15, 32'h5, 1, 5'(c + 1), 32'hD0 + 32'(c), 5'd2, 0, a, st);
      step(0, 1, 5'd15, 32'h5, 1, 5'd6, 32'hDD, 5'd2, 5'd6, a, st);
      repeat (6) step(1, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2, a, st);

      // randomized traffic; W holds its request while stalled
      hold = 0; pv = 0; pa3 = 0; pwd = 0;
      for (int c = 0; c < 600; c++) begin
         if (!hold) begin
            pv  = $urandom_range(0, 99) < 60;
            pa3 = 5'($urandom_range(0, 7));
            pwd = $urandom;
         end
         step($urandom_range(0, 149) != 0, pv, pa3, pwd,
              $urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), a, st);
         hold = st;
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drain", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
